// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write scheduler.
// Holds the sequencer state enum, default geometry/preset values and requester ids.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam int              PRE0_IDX = 9;
    localparam logic [31:0]     PRE0_VAL = 32'd5;
    localparam int              PRE1_IDX = 10;
    localparam logic [31:0]     PRE1_VAL = 32'd30;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    typedef enum logic [1:0] {
        CLEAR,
        PRE0,
        PRE1,
        RUN
    } state_t;

endpackage

// File: rtl/regfile_write_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins; on a tie the
// pointed-to side wins and the pointer moves to the side that lost.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import regfile_pkg::*;

    logic ptr_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt[REQ_A] = 1'b1;
            2'b10:   gnt[REQ_B] = 1'b1;
            2'b11:   gnt[ptr_q] = 1'b1;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'(REQ_A);
        end else if (req == 2'b11) begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Sole owner of the register-file write port: clears and presets the file after
// reset, then arbitrates two writeback requesters and tracks pending writes.
// Optional read-port bypass outputs are enabled with `define REGFILE_WR_FWD_EN.
module regfile_write_sched #(
    parameter int                      DATA_W   = regfile_pkg::DATA_W,
    parameter int                      ADDR_W   = regfile_pkg::ADDR_W,
    parameter int                      PRE0_IDX = regfile_pkg::PRE0_IDX,
    parameter logic [DATA_W-1:0]       PRE0_VAL = regfile_pkg::PRE0_VAL,
    parameter int                      PRE1_IDX = regfile_pkg::PRE1_IDX,
    parameter logic [DATA_W-1:0]       PRE1_VAL = regfile_pkg::PRE1_VAL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [ADDR_W-1:0]      a_addr,
    input  logic [DATA_W-1:0]      a_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [ADDR_W-1:0]      b_addr,
    input  logic [DATA_W-1:0]      b_data,
    input  logic                   claim_valid,
    input  logic [ADDR_W-1:0]      claim_addr,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic                   init_done,
    output logic [2**ADDR_W-1:0]   pending
`ifdef REGFILE_WR_FWD_EN
    ,
    output logic                   fwd_valid,
    output logic [ADDR_W-1:0]      fwd_addr,
    output logic [DATA_W-1:0]      fwd_data
`endif
);
    import regfile_pkg::*;

    localparam int NREG = 2**ADDR_W;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic                 we_d;
    logic [ADDR_W-1:0]    waddr_d;
    logic [DATA_W-1:0]    wdata_d;
    logic                 done_d;
    logic                 run_wr_q, run_wr_d;
    logic [NREG-1:0]      pending_d;
    logic                 in_run;
    logic [1:0]           req, gnt;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;

    assign in_run = (state_q == RUN);

    always_comb begin
        req        = 2'b00;
        req[REQ_A] = a_valid && in_run;
        req[REQ_B] = b_valid && in_run;
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign a_ready  = gnt[REQ_A];
    assign b_ready  = gnt[REQ_B];
    assign sel_addr = gnt[REQ_B] ? b_addr : a_addr;
    assign sel_data = gnt[REQ_B] ? b_data : a_data;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = 1'b0;
        waddr_d  = rf_waddr;
        wdata_d  = rf_wdata;
        done_d   = init_done;
        run_wr_d = 1'b0;
        case (state_q)
            CLEAR: begin
                we_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = '0;
                idx_d   = idx_q + 1'b1;
                if (idx_q == ADDR_W'(NREG - 1)) state_d = PRE0;
            end
            PRE0: begin
                we_d    = 1'b1;
                waddr_d = ADDR_W'(PRE0_IDX);
                wdata_d = PRE0_VAL;
                state_d = PRE1;
            end
            PRE1: begin
                we_d    = 1'b1;
                waddr_d = ADDR_W'(PRE1_IDX);
                wdata_d = PRE1_VAL;
                state_d = RUN;
                done_d  = 1'b1;
            end
            RUN: begin
                // Register 0 is hardwired: its writes are accepted and silently dropped.
                if ((|gnt) && (sel_addr != '0)) begin
                    we_d     = 1'b1;
                    run_wr_d = 1'b1;
                    waddr_d  = sel_addr;
                    wdata_d  = sel_data;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        pending_d = pending;
        if (in_run) begin
            if (run_wr_q) pending_d[rf_waddr] = 1'b0;
            // A claim applied after the commit clear lets a same-cycle claim win.
            if (claim_valid && (claim_addr != '0)) pending_d[claim_addr] = 1'b1;
        end
    end

    // NOTE: only control and output flops exist here, so all of them are reset; the register file itself lives elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            idx_q     <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            init_done <= 1'b0;
            run_wr_q  <= 1'b0;
            pending   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rf_we     <= we_d;
            rf_waddr  <= waddr_d;
            rf_wdata  <= wdata_d;
            init_done <= done_d;
            run_wr_q  <= run_wr_d;
            pending   <= pending_d;
        end
    end

`ifdef REGFILE_WR_FWD_EN
    assign fwd_valid = run_wr_q;
    assign fwd_addr  = run_wr_q ? rf_waddr : '0;
    assign fwd_data  = run_wr_q ? rf_wdata : '0;
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Self-checking bench for regfile_write_sched: init sequence, round-robin
// writeback, register-0 drop, pending scoreboard and mid-init reset.
module tb_regfile_write_sched;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_valid, b_valid, claim_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr, claim_addr;
    logic [DW-1:0] a_data, b_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          init_done;
    logic [31:0]   pending;
`ifdef REGFILE_WR_FWD_EN
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    logic rr_ptr;
    logic [31:0] pend_exp;

    regfile_write_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .init_done   (init_done),
        .pending     (pending)
`ifdef REGFILE_WR_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Runs (or aborts) the post-reset init; rst_n must be low on entry.
    task automatic init_seq(input int abort_at);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'hBBBB;
        claim_valid = 1'b1; claim_addr = 5'd7;
        #1;
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_init_done", init_done, 0);
        check("rst_pending", pending, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            ea = (k <= 32) ? AW'(k - 1) : ((k == 33) ? 5'd9 : 5'd10);
            ed = (k <= 32) ? 32'd0 : ((k == 33) ? 32'd5 : 32'd30);
            check("init_we", rf_we, 1);
            check("init_waddr", rf_waddr, ea);
            check("init_wdata", rf_wdata, ed);
            check("init_done", init_done, (k == 34));
            check("init_a_ready", a_ready, 0);
            check("init_b_ready", b_ready, 0);
`ifdef REGFILE_WR_FWD_EN
            check("init_fwd_valid", fwd_valid, 0);
`endif
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_we", rf_we, 0);
                check("abort_waddr", rf_waddr, 0);
                check("abort_init_done", init_done, 0);
                return;
            end
            if (k == 33) begin
                a_valid = 1'b0; b_valid = 1'b0; claim_valid = 1'b0;
            end
        end
        check("init_pending", pending, 0);
        exp_q.delete();
        exp_q.push_back('{we: 1'b0, addr: '0, data: '0});
        pend_exp = '0;
        rr_ptr   = 1'b0;
    endtask

    // One RUN cycle: check last cycle's output, drive new requests, predict the next output.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input logic cv, input logic [AW-1:0] ca);
        exp_t e, nx;
        logic ga, gb;
        @(negedge clk);
        e = exp_q.pop_front();
        check("run_we", rf_we, e.we);
        if (e.we) begin
            check("run_waddr", rf_waddr, e.addr);
            check("run_wdata", rf_wdata, e.data);
        end
        check("pending", pending, pend_exp);
`ifdef REGFILE_WR_FWD_EN
        check("fwd_valid", fwd_valid, e.we);
        if (e.we) begin
            check("fwd_addr", fwd_addr, e.addr);
            check("fwd_data", fwd_data, e.data);
        end
`endif
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        claim_valid = cv; claim_addr = ca;
        #1;
        ga = av && (!bv || !rr_ptr);
        gb = bv && (!av || rr_ptr);
        if (av && bv) rr_ptr = ~rr_ptr;
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        if (e.we) pend_exp[e.addr] = 1'b0;
        if (cv && ca != '0) pend_exp[ca] = 1'b1;
        nx.addr = gb ? ba : aa;
        nx.data = gb ? bd : ad;
        nx.we   = (ga || gb) && (nx.addr != '0);
        exp_q.push_back(nx);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        claim_valid = 1'b0; claim_addr = '0;
        rr_ptr = 1'b0;
        pend_exp = '0;
        repeat (2) @(posedge clk);

        init_seq(0);

        // Contention: grants alternate A,B,A,B
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd3, 32'hA0 + i, 1'b1, 5'd4, 32'hB0 + i, 1'b0, '0);
        idle();

        // Register 0 write is accepted but never committed
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0, 1'b0, '0);
        idle();

        // Claim then commit clears the bit
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        idle();
        step(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b0, '0);
        idle();
        idle();

        // Claim in the commit cycle keeps the bit set
        step(1'b1, 5'd7, 32'h88, 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        idle();
        step(1'b1, 5'd7, 32'h99, 1'b0, '0, '0, 1'b0, '0);
        idle();
        idle();

        // Claim of register 0 is ignored
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0);
        idle();

        // Same destination from both sides
        step(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, '0);
        step(1'b1, 5'd5, 32'h33, 1'b1, 5'd5, 32'h44, 1'b0, '0);
        idle();

        // B-side write, also exercising the bypass when enabled
        step(1'b0, '0, '0, 1'b1, 5'd5, 32'h1234, 1'b0, '0);
        idle();

        // Mixed random traffic
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12);
        idle();

        // Reset in the middle of init, then a full init again
        @(negedge clk);
        rst_n = 1'b0;
        init_seq(13);
        init_seq(0);
        step(1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b0, '0);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
